udp_ipv4_tx: RTL and testbench
==============================

// Module: udp_ipv4_tx
// PURPOSE
//  Transmit-side UDP + IPv4 framer: prepends a 20 B IPv4 header (no options) and an 8 B UDP header to an app payload stream.
//  Streams the payload to the MAC tx path with zero added latency.
//  Sits between the application and mac_tx; it is the transmit counterpart of the ipv4_rx/udp_rx receive path.
//  UDP checksum is sent as 0x0000 (legal for IPv4); IPv4 header checksum is computed per packet.
// PARAMETERS
//  DATA_W      16                 datapath width; only 16 is supported (28 B header = 14 beats); elaboration error otherwise
//  KEEP_W      DATA_W/8           bytes per beat
//  LEN_W       $clog2(KEEP_W+1)   valid-byte count width
//  SRC_ADDR    206.200.127.128    IPv4 source address, 32 b
//  DST_ADDR    206.200.127.128    IPv4 destination address, 32 b
//  SRC_PORT    18070              UDP source port, 16 b
//  DST_PORT    18070              UDP destination port, 16 b
//  TTL         64                 IPv4 TTL, 8 b
//  TOS         0                  IPv4 DSCP/ECN byte, 8 b
// PORTS
//  clk             in   1        clock
//  nreset          in   1        reset; synchronous, active-high (1 = reset)
//  app_start_i     in   1        request new packet; sampled only in IDLE
//  app_pkt_len_i   in   16       payload bytes for this packet; valid with app_start_i
//  app_valid_i     in   1        payload beat valid
//  app_data_i      in   DATA_W   payload beat; byte 0 on wire = [7:0]
//  app_ready_o     out  1        payload beat accepted when app_valid_i & app_ready_o
//  app_cancel_i    in   1        abort current packet
//  busy_o          out  1        packet in progress (not IDLE)
//  err_o           out  1        1-cycle pulse: start rejected (length too large)
//  tx_valid_o      out  1        beat valid toward MAC
//  tx_data_o       out  DATA_W   beat data; byte 0 on wire = [7:0]
//  tx_len_o        out  LEN_W    valid bytes in beat, low lanes first
//  tx_last_o       out  1        final beat of frame
//  tx_ready_i      in   1        MAC accepts beat when tx_valid_o & tx_ready_i
//  tx_cancel_o     out  1        abort frame toward MAC
// BEHAVIOUR
//  Reset: state IDLE, hdr_cnt=0, byte_cnt=0, ip_id=0; all outputs 0.
//  IDLE:
//   - app_start_i & app_pkt_len_i<=65507: latch len, precompute total_len=len+28, udp_len=len+8, checksum; go HDR.
//   - Length >65507: err_o=1 for one cycle; stay IDLE.
//  HDR:
//   - tx_valid_o=1, tx_len_o=2, app_ready_o=0.
//   - Word hdr_cnt 0..13 in wire order: 0x4500|TOS, total_len, ip_id, 0x4000 (DF), {TTL,8'd17}, csum,
//     src[31:16], src[15:0], dst[31:16], dst[15:0], SRC_PORT, DST_PORT, udp_len, 0x0000.
//   - Each 16 b word is placed big-endian on the wire: first byte in [7:0].
//   - hdr_cnt advances on tx_ready_i.
//   - After word 13 accepted: len==0 -> tx_last_o was 1 on word 13, go IDLE; else go PAYLOAD.
//  PAYLOAD:
//   - Combinational passthrough: tx_valid_o=app_valid_i, app_ready_o=tx_ready_i, tx_data_o=app_data_i.
//   - tx_len_o=min(remaining,2); tx_last_o=(remaining<=2). remaining decremented by tx_len_o per transfer.
//   - Last transfer -> IDLE, ip_id+=1 (wraps 0xFFFF->0).
//  Checksum: ~fold16(sum of 10 IPv4 header words with csum=0).
//   - Constant words summed at elaboration; total_len and ip_id added in IDLE.
//   - Registered before HDR word 5 is reached. First header beat is valid the cycle after start is accepted.
//  Cancel: app_cancel_i in HDR/PAYLOAD -> tx_cancel_o=1 same cycle, tx_valid_o=0, next state IDLE, ip_id still increments.
//   - Ignored in IDLE.
//  tx_ready_i low holds all outputs stable (AXI-style; valid never drops without cancel).
//  Reset mid-packet: immediate IDLE, no cancel emitted.
//  app_start_i outside IDLE is ignored.
// STRUCTURE
//  eth_pkg: IPv4 header constants (version/IHL, DF flag, PROT_UDP=17, header lengths 20/8), header field typedef.
//  Sub-module ones_cs_add: 16 b ones-complement add with end-around carry, reused for fold.
//  FSM enum {IDLE,HDR,PAYLOAD} local.
// TESTING
//  1. len=4, ID=0, defaults -> 14 hdr beats: 4500,0020,0000,4000,4011,9E3B,CEC8,7F80,CEC8,7F80,4696,4696,000C,0000;
//     then 2 payload beats, last len=2, tx_last_o on beat 16.
//  2. len=3 -> 2 payload beats, tx_len_o=2 then 1, tx_last_o on 2nd; next packet ID=0x0001.
//  3. len=0 -> 14 beats only, tx_last_o on word 13 (UDP csum 0000), app_ready_o never high.
//  4. tx_ready_i toggles 0/1 each cycle in HDR and PAYLOAD -> identical byte stream, data stable while stalled.
//  5. app_cancel_i at hdr word 7 -> tx_cancel_o pulse, IDLE next cycle; next packet ID incremented, sends fully.
//  6. app_pkt_len_i=65508 -> err_o 1-cycle pulse, busy_o stays 0; 65507 -> total_len=0xFFFF accepted.

Source files
------------

// File: rtl/udp_ipv4_tx_pkg.sv
// Shared IPv4/UDP header constants and helpers for the UDP transmit framer.
package udp_ipv4_tx_pkg;

    localparam logic [15:0] IP_VER_IHL   = 16'h4500;  // version 4, IHL 5, TOS ORed in by user
    localparam logic [15:0] IP_FLAGS_DF  = 16'h4000;
    localparam logic [7:0]  PROT_UDP     = 8'd17;
    localparam int unsigned IP_HDR_LEN   = 20;
    localparam int unsigned UDP_HDR_LEN  = 8;
    localparam int unsigned HDR_LEN      = IP_HDR_LEN + UDP_HDR_LEN;
    localparam int unsigned HDR_WORDS    = HDR_LEN / 2;
    localparam int unsigned MAX_PAYLOAD  = 65535 - HDR_LEN;

    typedef enum logic [3:0] {
        HwVerTos, HwTotalLen, HwIpId, HwFlags, HwTtlProt, HwCsum,
        HwSrcHi, HwSrcLo, HwDstHi, HwDstLo,
        HwSrcPort, HwDstPort, HwUdpLen, HwUdpCsum
    } hdr_word_e;

    function automatic logic [15:0] ones_fold32(input logic [31:0] s);
        logic [31:0] t;
        t = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        t = {16'd0, t[15:0]} + {16'd0, t[31:16]};
        return t[15:0];
    endfunction

endpackage

// File: rtl/udp_ipv4_tx_ones_cs_add.sv
// 16-bit ones-complement adder with end-around carry.
module udp_ipv4_tx_ones_cs_add (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);

    logic [16:0] raw;

    assign raw   = {1'b0, a_i} + {1'b0, b_i};
    assign sum_o = raw[15:0] + {15'd0, raw[16]};

endmodule

// File: rtl/udp_ipv4_tx.sv
// UDP/IPv4 transmit framer: emits a 28-byte header, then passes the payload through to the MAC.
module udp_ipv4_tx
    import udp_ipv4_tx_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned KEEP_W   = DATA_W / 8,
    parameter int unsigned LEN_W    = $clog2(KEEP_W + 1),
    parameter logic [31:0] SRC_ADDR = 32'hCEC8_7F80,
    parameter logic [31:0] DST_ADDR = 32'hCEC8_7F80,
    parameter logic [15:0] SRC_PORT = 16'd18070,
    parameter logic [15:0] DST_PORT = 16'd18070,
    parameter logic [7:0]  TTL      = 8'd64,
    parameter logic [7:0]  TOS      = 8'd0
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              app_start_i,
    input  logic [15:0]       app_pkt_len_i,
    input  logic              app_valid_i,
    input  logic [DATA_W-1:0] app_data_i,
    output logic              app_ready_o,
    input  logic              app_cancel_i,
    output logic              busy_o,
    output logic              err_o,
    output logic              tx_valid_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic [LEN_W-1:0]  tx_len_o,
    output logic              tx_last_o,
    input  logic              tx_ready_i,
    output logic              tx_cancel_o
);

    if (DATA_W != 16) begin : g_bad_width
        $error("udp_ipv4_tx supports DATA_W == 16 only");
    end

    typedef enum logic [1:0] {StIdle, StHdr, StPayload} state_e;

    // Fixed header words folded once at elaboration.
    localparam logic [31:0] ConstRaw = {16'd0, IP_VER_IHL | {8'd0, TOS}} + {16'd0, IP_FLAGS_DF}
        + {16'd0, TTL, PROT_UDP} + {16'd0, SRC_ADDR[31:16]} + {16'd0, SRC_ADDR[15:0]}
        + {16'd0, DST_ADDR[31:16]} + {16'd0, DST_ADDR[15:0]};
    localparam logic [15:0] ConstSum = ones_fold32(ConstRaw);

    state_e      state_q;
    logic [3:0]  hdr_cnt_q;
    logic [15:0] byte_cnt_q, total_len_q, udp_len_q, ip_id_q, csum_q;
    logic        err_q;

    logic [15:0] total_len_d, udp_len_d, sum_len, sum_id;
    logic        start_ok;
    logic [15:0] hdr_word;

    assign total_len_d = app_pkt_len_i + 16'(HDR_LEN);
    assign udp_len_d   = app_pkt_len_i + 16'(UDP_HDR_LEN);
    assign start_ok    = app_pkt_len_i <= 16'(MAX_PAYLOAD);

    udp_ipv4_tx_ones_cs_add u_add_len (
        .a_i   (ConstSum),
        .b_i   (total_len_d),
        .sum_o (sum_len)
    );

    udp_ipv4_tx_ones_cs_add u_add_id (
        .a_i   (sum_len),
        .b_i   (ip_id_q),
        .sum_o (sum_id)
    );

    always_ff @(posedge clk) begin
        if (nreset) begin
            state_q     <= StIdle;
            hdr_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            total_len_q <= '0;
            udp_len_q   <= '0;
            ip_id_q     <= '0;
            csum_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (app_start_i) begin
                        if (start_ok) begin
                            state_q     <= StHdr;
                            hdr_cnt_q   <= '0;
                            byte_cnt_q  <= app_pkt_len_i;
                            total_len_q <= total_len_d;
                            udp_len_q   <= udp_len_d;
                            csum_q      <= ~sum_id;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StHdr: begin
                    if (app_cancel_i) begin
                        state_q    <= StIdle;
                        hdr_cnt_q  <= '0;
                        byte_cnt_q <= '0;
                        ip_id_q    <= ip_id_q + 16'd1;
                    end else if (tx_ready_i) begin
                        if (hdr_cnt_q == 4'(HDR_WORDS - 1)) begin
                            hdr_cnt_q <= '0;
                            if (byte_cnt_q == 16'd0) begin
                                state_q <= StIdle;
                                ip_id_q <= ip_id_q + 16'd1;
                            end else begin
                                state_q <= StPayload;
                            end
                        end else begin
                            hdr_cnt_q <= hdr_cnt_q + 4'd1;
                        end
                    end
                end
                StPayload: begin
                    if (app_cancel_i) begin
                        state_q    <= StIdle;
                        byte_cnt_q <= '0;
                        ip_id_q    <= ip_id_q + 16'd1;
                    end else if (app_valid_i && tx_ready_i) begin
                        byte_cnt_q <= byte_cnt_q - 16'(tx_len_o);
                        if (tx_last_o) begin
                            state_q <= StIdle;
                            ip_id_q <= ip_id_q + 16'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        hdr_word = 16'h0000;
        case (hdr_word_e'(hdr_cnt_q))
            HwVerTos:   hdr_word = IP_VER_IHL | {8'd0, TOS};
            HwTotalLen: hdr_word = total_len_q;
            HwIpId:     hdr_word = ip_id_q;
            HwFlags:    hdr_word = IP_FLAGS_DF;
            HwTtlProt:  hdr_word = {TTL, PROT_UDP};
            HwCsum:     hdr_word = csum_q;
            HwSrcHi:    hdr_word = SRC_ADDR[31:16];
            HwSrcLo:    hdr_word = SRC_ADDR[15:0];
            HwDstHi:    hdr_word = DST_ADDR[31:16];
            HwDstLo:    hdr_word = DST_ADDR[15:0];
            HwSrcPort:  hdr_word = SRC_PORT;
            HwDstPort:  hdr_word = DST_PORT;
            HwUdpLen:   hdr_word = udp_len_q;
            default:    hdr_word = 16'h0000;
        endcase
    end

    always_comb begin
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        tx_len_o    = '0;
        tx_last_o   = 1'b0;
        tx_cancel_o = 1'b0;
        app_ready_o = 1'b0;
        unique case (state_q)
            StHdr: begin
                if (app_cancel_i) begin
                    tx_cancel_o = 1'b1;
                end else begin
                    tx_valid_o = 1'b1;
                    // Network byte order: high byte of each word goes out first.
                    tx_data_o  = {hdr_word[7:0], hdr_word[15:8]};
                    tx_len_o   = LEN_W'(KEEP_W);
                    tx_last_o  = (hdr_cnt_q == 4'(HDR_WORDS - 1)) && (byte_cnt_q == 16'd0);
                end
            end
            StPayload: begin
                if (app_cancel_i) begin
                    tx_cancel_o = 1'b1;
                end else begin
                    tx_valid_o  = app_valid_i;
                    app_ready_o = tx_ready_i;
                    tx_data_o   = app_data_i;
                    tx_len_o    = (byte_cnt_q < 16'(KEEP_W)) ? byte_cnt_q[LEN_W-1:0]
                                                              : LEN_W'(KEEP_W);
                    tx_last_o   = byte_cnt_q <= 16'(KEEP_W);
                end
            end
            default: ;
        endcase
    end

    assign busy_o = state_q != StIdle;
    assign err_o  = err_q;

endmodule

// File: tb/tb_udp_ipv4_tx.sv
// Directed bench for udp_ipv4_tx: header words, payload passthrough, stalls, cancel and length limit.
module tb_udp_ipv4_tx;

    logic        clk = 1'b0;
    logic        nreset;
    logic        app_start_i;
    logic [15:0] app_pkt_len_i;
    logic        app_valid_i;
    logic [15:0] app_data_i;
    logic        app_ready_o;
    logic        app_cancel_i;
    logic        busy_o;
    logic        err_o;
    logic        tx_valid_o;
    logic [15:0] tx_data_o;
    logic [1:0]  tx_len_o;
    logic        tx_last_o;
    logic        tx_ready_i;
    logic        tx_cancel_o;

    udp_ipv4_tx dut (
        .clk           (clk),
        .nreset        (nreset),
        .app_start_i   (app_start_i),
        .app_pkt_len_i (app_pkt_len_i),
        .app_valid_i   (app_valid_i),
        .app_data_i    (app_data_i),
        .app_ready_o   (app_ready_o),
        .app_cancel_i  (app_cancel_i),
        .busy_o        (busy_o),
        .err_o         (err_o),
        .tx_valid_o    (tx_valid_o),
        .tx_data_o     (tx_data_o),
        .tx_len_o      (tx_len_o),
        .tx_last_o     (tx_last_o),
        .tx_ready_i    (tx_ready_i),
        .tx_cancel_o   (tx_cancel_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] cap_data [64];
    logic [1:0]  cap_len  [64];
    logic        cap_last [64];
    int          n_cap;
    int          stall_viol;
    bit          timed_out, cancel_seen, any_app_ready, busy_after, cancel_after;
    logic [15:0] exp_w [14];

    // Runs one packet; payload byte k is 8'hA0 + k. Cancels while header word cancel_at is shown.
    task automatic send_pkt(input int len, input bit toggle, input int cancel_at);
        int cyc, pay_idx;
        bit done, prev_stall;
        logic [15:0] pd;
        logic [1:0] pl;
        logic plast;
        n_cap = 0; stall_viol = 0; cancel_seen = 0; any_app_ready = 0;
        pay_idx = 0; done = 0; prev_stall = 0; cyc = 0;
        pd = '0; pl = '0; plast = 1'b0;
        @(negedge clk);
        app_start_i = 1'b1;
        app_pkt_len_i = 16'(len);
        @(negedge clk);
        app_start_i = 1'b0;
        while (!done && cyc < 400) begin
            tx_ready_i   = toggle ? cyc[0] : 1'b1;
            app_valid_i  = 1'b1;
            app_data_i   = {8'(8'hA1 + 2 * pay_idx), 8'(8'hA0 + 2 * pay_idx)};
            app_cancel_i = (cancel_at >= 0) && (n_cap == cancel_at);
            #1;
            if (prev_stall && (!tx_valid_o || tx_data_o !== pd || tx_len_o !== pl
                               || tx_last_o !== plast))
                stall_viol++;
            if (app_ready_o) any_app_ready = 1;
            if (app_cancel_i) begin
                cancel_seen = tx_cancel_o && !tx_valid_o;
                done = 1;
            end else if (tx_valid_o && tx_ready_i) begin
                if (n_cap < 64) begin
                    cap_data[n_cap] = tx_data_o;
                    cap_len[n_cap]  = tx_len_o;
                    cap_last[n_cap] = tx_last_o;
                end
                n_cap++;
                if (app_ready_o) pay_idx++;
                if (tx_last_o) done = 1;
            end
            prev_stall = tx_valid_o && !tx_ready_i && !app_cancel_i;
            pd = tx_data_o; pl = tx_len_o; plast = tx_last_o;
            cyc++;
            @(negedge clk);
        end
        app_cancel_i = 1'b0;
        app_valid_i  = 1'b0;
        tx_ready_i   = 1'b1;
        timed_out    = !done;
        #1;
        busy_after   = busy_o;
        cancel_after = tx_cancel_o;
    endtask

    task automatic set_hdr(input logic [15:0] tot, input logic [15:0] id,
                           input logic [15:0] cs, input logic [15:0] ulen);
        exp_w = '{16'h4500, tot, id, 16'h4000, 16'h4011, cs, 16'hCEC8, 16'h7F80,
                  16'hCEC8, 16'h7F80, 16'h4696, 16'h4696, ulen, 16'h0000};
    endtask

    task automatic test_reset();
        nreset = 1'b1; app_start_i = 1'b1; app_pkt_len_i = 16'd4; app_valid_i = 1'b0;
        app_data_i = '0; app_cancel_i = 1'b0; tx_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy_o, err_o, tx_valid_o, tx_last_o, tx_cancel_o, app_ready_o} !== 6'b0
            || tx_data_o !== 16'h0 || tx_len_o !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b err=%b valid=%b data=%h len=%0d exp all zero",
                     busy_o, err_o, tx_valid_o, tx_data_o, tx_len_o);
        end
        app_start_i = 1'b0;
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || tx_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b valid=%b exp 0 0", busy_o, tx_valid_o);
        end
    endtask

    task automatic test_len4();
        logic [15:0] w;
        logic [15:0] lit [14] = '{16'h4500, 16'h0020, 16'h0000, 16'h4000, 16'h4011, 16'h9E3B,
            16'hCEC8, 16'h7F80, 16'hCEC8, 16'h7F80, 16'h4696, 16'h4696, 16'h000C, 16'h0000};
        send_pkt(4, 1'b0, -1);
        checks++;
        if (timed_out || n_cap !== 16 || busy_after !== 1'b0) begin
            failures++;
            $display("FAIL len4_count got beats=%0d timeout=%b busy=%b exp 16 0 0",
                     n_cap, timed_out, busy_after);
        end
        for (int i = 0; i < 14; i++) begin
            w = lit[i];
            checks++;
            if (cap_data[i] !== {w[7:0], w[15:8]} || cap_len[i] !== 2'd2 || cap_last[i] !== 1'b0) begin
                failures++;
                $display("FAIL len4_hdr[%0d] got data=%h len=%0d last=%b exp data=%h len=2 last=0",
                         i, cap_data[i], cap_len[i], cap_last[i], {w[7:0], w[15:8]});
            end
        end
        checks++;
        if (cap_data[14] !== 16'hA1A0 || cap_len[14] !== 2'd2 || cap_last[14] !== 1'b0
            || cap_data[15] !== 16'hA3A2 || cap_len[15] !== 2'd2 || cap_last[15] !== 1'b1) begin
            failures++;
            $display("FAIL len4_payload got %h/%0d/%b %h/%0d/%b exp a1a0/2/0 a3a2/2/1",
                     cap_data[14], cap_len[14], cap_last[14], cap_data[15], cap_len[15], cap_last[15]);
        end
    endtask

    task automatic test_len3();
        logic [15:0] w;
        send_pkt(3, 1'b0, -1);
        set_hdr(16'h001F, 16'h0001, 16'h9E3B, 16'h000B);
        checks++;
        if (timed_out || n_cap !== 16) begin
            failures++;
            $display("FAIL len3_count got beats=%0d timeout=%b exp 16 0", n_cap, timed_out);
        end
        for (int i = 0; i < 14; i++) begin
            w = exp_w[i];
            checks++;
            if (cap_data[i] !== {w[7:0], w[15:8]} || cap_last[i] !== 1'b0) begin
                failures++;
                $display("FAIL len3_hdr[%0d] got data=%h last=%b exp data=%h last=0",
                         i, cap_data[i], cap_last[i], {w[7:0], w[15:8]});
            end
        end
        checks++;
        if (cap_data[14] !== 16'hA1A0 || cap_len[14] !== 2'd2 || cap_last[14] !== 1'b0
            || cap_data[15] !== 16'hA3A2 || cap_len[15] !== 2'd1 || cap_last[15] !== 1'b1) begin
            failures++;
            $display("FAIL len3_payload got %h/%0d/%b %h/%0d/%b exp a1a0/2/0 a3a2/1/1",
                     cap_data[14], cap_len[14], cap_last[14], cap_data[15], cap_len[15], cap_last[15]);
        end
    endtask

    task automatic test_len0();
        logic [15:0] w;
        send_pkt(0, 1'b0, -1);
        set_hdr(16'h001C, 16'h0002, 16'h9E3D, 16'h0008);
        checks++;
        if (timed_out || n_cap !== 14 || any_app_ready || busy_after !== 1'b0) begin
            failures++;
            $display("FAIL len0_shape got beats=%0d timeout=%b app_ready_seen=%b busy=%b exp 14 0 0 0",
                     n_cap, timed_out, any_app_ready, busy_after);
        end
        for (int i = 0; i < 14; i++) begin
            w = exp_w[i];
            checks++;
            if (cap_data[i] !== {w[7:0], w[15:8]} || cap_last[i] !== (i == 13)) begin
                failures++;
                $display("FAIL len0_hdr[%0d] got data=%h last=%b exp data=%h last=%b",
                         i, cap_data[i], cap_last[i], {w[7:0], w[15:8]}, (i == 13));
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] w;
        send_pkt(4, 1'b1, -1);
        set_hdr(16'h0020, 16'h0003, 16'h9E38, 16'h000C);
        checks++;
        if (timed_out || n_cap !== 16 || stall_viol !== 0) begin
            failures++;
            $display("FAIL stall_shape got beats=%0d timeout=%b unstable=%0d exp 16 0 0",
                     n_cap, timed_out, stall_viol);
        end
        for (int i = 0; i < 14; i++) begin
            w = exp_w[i];
            checks++;
            if (cap_data[i] !== {w[7:0], w[15:8]}) begin
                failures++;
                $display("FAIL stall_hdr[%0d] got %h exp %h", i, cap_data[i], {w[7:0], w[15:8]});
            end
        end
        checks++;
        if (cap_data[14] !== 16'hA1A0 || cap_data[15] !== 16'hA3A2 || cap_last[15] !== 1'b1) begin
            failures++;
            $display("FAIL stall_payload got %h %h last=%b exp a1a0 a3a2 last=1",
                     cap_data[14], cap_data[15], cap_last[15]);
        end
    endtask

    task automatic test_cancel();
        logic [15:0] w;
        send_pkt(4, 1'b0, 7);
        checks++;
        if (!cancel_seen || n_cap !== 7 || busy_after !== 1'b0 || cancel_after !== 1'b0) begin
            failures++;
            $display("FAIL cancel_pulse got seen=%b beats=%0d busy=%b cancel_next=%b exp 1 7 0 0",
                     cancel_seen, n_cap, busy_after, cancel_after);
        end
        send_pkt(2, 1'b0, -1);
        set_hdr(16'h001E, 16'h0005, 16'h9E38, 16'h000A);
        checks++;
        if (timed_out || n_cap !== 15 || cap_data[14] !== 16'hA1A0 || cap_last[14] !== 1'b1) begin
            failures++;
            $display("FAIL after_cancel got beats=%0d timeout=%b data=%h last=%b exp 15 0 a1a0 1",
                     n_cap, timed_out, cap_data[14], cap_last[14]);
        end
        for (int i = 0; i < 14; i++) begin
            w = exp_w[i];
            checks++;
            if (cap_data[i] !== {w[7:0], w[15:8]}) begin
                failures++;
                $display("FAIL after_cancel_hdr[%0d] got %h exp %h", i, cap_data[i], {w[7:0], w[15:8]});
            end
        end
    endtask

    task automatic test_len_limit();
        @(negedge clk);
        app_start_i = 1'b1;
        app_pkt_len_i = 16'd65508;
        @(negedge clk);
        app_start_i = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL len_reject got err=%b busy=%b exp 1 0", err_o, busy_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse_width got err=%b busy=%b exp 0 0", err_o, busy_o);
        end
        send_pkt(65507, 1'b0, 6);
        checks++;
        if (n_cap !== 6 || cap_data[1] !== 16'hFFFF || cap_data[2] !== 16'h0600
            || cap_data[5] !== 16'h559E || !cancel_seen) begin
            failures++;
            $display("FAIL len_max got beats=%0d tot=%h id=%h csum=%h cancel=%b exp 6 ffff 0600 559e 1",
                     n_cap, cap_data[1], cap_data[2], cap_data[5], cancel_seen);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        app_start_i = 1'b1;
        app_pkt_len_i = 16'd4;
        @(negedge clk);
        app_start_i = 1'b0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || tx_valid_o !== 1'b0 || tx_cancel_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b valid=%b cancel=%b exp 0 0 0",
                     busy_o, tx_valid_o, tx_cancel_o);
        end
        nreset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_len4();
        test_len3();
        test_len0();
        test_stall();
        test_cancel();
        test_len_limit();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
